// File: rtl/conv_pixel_feeder_pkg.sv
// Shared types and constants for the convolution pixel feeder.
// CONV_FEEDER_PAD_EN: zero-pad an im x im buffer; otherwise the buffer is pre-padded img x img.
package conv_pkg;
  localparam int N      = 7;
  localparam int STRIDE = 5;
  localparam int IM     = 28;
  localparam int IMG    = IM + STRIDE - 1;
  localparam int PAD_LO = (STRIDE - 1) / 2;
  localparam int CW     = $clog2(IMG);
`ifdef CONV_FEEDER_PAD_EN
  localparam int AW     = $clog2(IM * IM);
`else
  localparam int AW     = $clog2(IMG * IMG);
`endif

  typedef logic [N:0] pixel_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    HOLD,
    DONE
  } feeder_state_e;
endpackage

// File: rtl/conv_pixel_feeder_if.sv
// Pixel stream and buffer read port of the feeder; address width follows CONV_FEEDER_PAD_EN.
interface conv_pixel_feeder_if;
  import conv_pkg::*;

  logic          start;
  logic          data_request;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  pixel_t        mem_rdata;
  pixel_t        data;
  logic          data_valid;
  logic          busy;
  logic          frame_done;

  modport master (
    input  start, data_request, mem_rdata,
    output mem_rd_en, mem_addr, data, data_valid, busy, frame_done
  );

  modport slave (
    output start, data_request, mem_rdata,
    input  mem_rd_en, mem_addr, data, data_valid, busy, frame_done
  );
endinterface

// File: rtl/conv_pixel_feeder_addr_gen.sv
// Row/col walk over the padded frame, in-bounds test and buffer address.
// CONV_FEEDER_PAD_EN enables the padding window; otherwise every coordinate is in-bounds.
module conv_feeder_addr_gen
  import conv_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_i,
  input  logic          advance_i,
  output logic          last_o,
  output logic          inb_o,
  output logic [AW-1:0] addr_o
);
  localparam logic [CW-1:0] LAST_IDX = CW'(IMG - 1);

  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
    end else if (advance_i) begin
      if (col_q == LAST_IDX) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign last_o = (row_q == LAST_IDX) && (col_q == LAST_IDX);

`ifdef CONV_FEEDER_PAD_EN
  localparam logic [CW-1:0] LO = CW'(PAD_LO);
  localparam logic [CW-1:0] HI = CW'(PAD_LO + IM);

  logic [CW-1:0] row_off;
  logic [CW-1:0] col_off;

  assign inb_o   = (row_q >= LO) && (row_q < HI) && (col_q >= LO) && (col_q < HI);
  assign row_off = row_q - LO;
  assign col_off = col_q - LO;
  // Gated so the address idles at 0 over the padding ring (and out of reset).
  assign addr_o  = inb_o ? (AW'(row_off) * AW'(IM) + AW'(col_off)) : '0;
`else
  assign inb_o   = 1'b1;
  assign addr_o  = AW'(row_q) * AW'(IMG) + AW'(col_q);
`endif
endmodule

// File: rtl/conv_pixel_feeder.sv
// Streams the img x img frame to the convolution engine, one pixel per request.
// CONV_FEEDER_PAD_EN selects on-the-fly zero padding (see conv_feeder_addr_gen).
//   state | meaning
//   IDLE  | waiting for start
//   FETCH | issue buffer read for in-bounds pixel
//   WAIT  | capture read data (or 0) into hold register
//   HOLD  | offer pixel until data_request, then advance
//   DONE  | one-cycle frame_done pulse
module conv_pixel_feeder
  import conv_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  conv_pixel_feeder_if.master bus
);
  feeder_state_e state_q, state_d;
  pixel_t        hold_q, hold_d;
  logic          clear;
  logic          advance;
  logic          last;
  logic          inb;
  logic          dvalid;
  logic [AW-1:0] addr;

  conv_feeder_addr_gen u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (clear),
    .advance_i (advance),
    .last_o    (last),
    .inb_o     (inb),
    .addr_o    (addr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    clear   = 1'b0;
    advance = 1'b0;
    dvalid  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          clear   = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: state_d = WAIT;
      WAIT: begin
        hold_d  = inb ? bus.mem_rdata : '0;
        state_d = HOLD;
      end
      HOLD: begin
        if (bus.data_request) begin
          dvalid  = 1'b1;
          advance = 1'b1;
          state_d = last ? DONE : FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_rd_en  = (state_q == FETCH) && inb;
  assign bus.mem_addr   = addr;
  assign bus.data       = hold_q;
  assign bus.data_valid = dvalid;
  assign bus.busy       = (state_q == FETCH) || (state_q == WAIT) || (state_q == HOLD);
  assign bus.frame_done = (state_q == DONE);
endmodule

// File: tb/tb_conv_pixel_feeder.sv
// Self-checking bench for conv_pixel_feeder; expected frames come from a padded-image model.
// Honours CONV_FEEDER_PAD_EN the same way the design does.
module tb_conv_pixel_feeder;
  localparam int T_IM  = 28;
  localparam int T_IMG = 32;
  localparam int T_PAD = 2;
  localparam int NPIX  = T_IMG * T_IMG;
`ifdef CONV_FEEDER_PAD_EN
  localparam int MEM_D  = T_IM * T_IM;
  localparam int RD_EXP = T_IM * T_IM;
`else
  localparam int MEM_D  = NPIX;
  localparam int RD_EXP = NPIX;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_pixel_feeder_if bus ();
  conv_pixel_feeder dut (.clk(clk), .reset(rst_n), .bus(bus));

  logic [7:0] mem [0:1023];
  logic [7:0] exp_q [$];
  logic [7:0] got [$];
  int         got_t [$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc_n    = 0;
  int fd_cnt   = 0;
  int rd_cnt   = 0;
  int viol     = 0;
  int t_start  = 0;
  int t_first  = 0;
  bit first_pending = 1'b0;

  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
  end

  always @(negedge clk) begin
    cyc_n++;
    if (rst_n && bus.start && !bus.busy && !bus.frame_done) begin
      t_start       = cyc_n;
      first_pending = 1'b1;
    end
    if (bus.data_valid) begin
      if (!bus.data_request || !bus.busy) viol++;
      if (first_pending) begin
        t_first       = cyc_n;
        first_pending = 1'b0;
      end
      got.push_back(bus.data);
      got_t.push_back(cyc_n);
    end
    if (bus.frame_done) fd_cnt++;
    if (bus.mem_rd_en) begin
      rd_cnt++;
      if (int'(bus.mem_addr) >= MEM_D) viol++;
    end
  end

  task automatic fill_mem(input bit rnd);
    for (int a = 0; a < 1024; a++) mem[a] = rnd ? 8'($urandom) : a[7:0];
  endtask

  // Frame model: walk the padded grid, zeros outside the image window.
  task automatic build_expected();
    exp_q.delete();
    for (int k = 0; k < NPIX; k++) begin
      int r;
      int c;
      r = k / T_IMG;
      c = k % T_IMG;
`ifdef CONV_FEEDER_PAD_EN
      if (r >= T_PAD && r < T_PAD + T_IM && c >= T_PAD && c < T_PAD + T_IM)
        exp_q.push_back(mem[(r - T_PAD) * T_IM + (c - T_PAD)]);
      else
        exp_q.push_back(8'h00);
`else
      exp_q.push_back(mem[r * T_IMG + c]);
`endif
    end
  endtask

  function automatic int seq_errs(input int base, output int first_bad);
    int n = 0;
    first_bad = -1;
    for (int k = 0; k < NPIX; k++) begin
      if (base + k >= got.size() || got[base + k] !== exp_q[k]) begin
        if (first_bad < 0) first_bad = k;
        n++;
      end
    end
    return n;
  endfunction

  function automatic int min_gap(input int base);
    int m = 1 << 30;
    for (int k = base + 1; k < got_t.size(); k++)
      if (got_t[k] - got_t[k - 1] < m) m = got_t[k] - got_t[k - 1];
    return m;
  endfunction

  task automatic hold_check(input logic [7:0] held);
    int bad_dv = 0;
    int bad_data = 0;
    bus.data_request = 1'b0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (bus.data_valid) bad_dv++;
      if (i >= 2 && bus.data !== held) bad_data++;
    end
    @(posedge clk); #1;
    n_checks++;
    if (bad_dv !== 0) begin
      n_fail++; $display("FAIL hold_low_valid: data_valid high %0d cycles, required 0", bad_dv);
    end
    n_checks++;
    if (bad_data !== 0) begin
      n_fail++; $display("FAIL hold_low_data: %0d cycles with data=%0h, required %0h", bad_data, bus.data, held);
    end
  endtask

  task automatic run_frame(input int mode, input int restart_at, input int abort_at,
                           input int pause_at, input bit done_start,
                           output int base, output int fd0, output bit timeout);
    int cycles = 0;
    int n;
    bit restarted = 1'b0;
    bit paused = 1'b0;
    bit dstart = 1'b0;
    base = got.size();
    fd0 = fd_cnt;
    timeout = 1'b0;
    bus.data_request = (mode == 0);
    @(posedge clk); #1 bus.start = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      cycles++;
      n = got.size() - base;
      if (fd_cnt != fd0) break;
      if (abort_at >= 0 && n >= abort_at) break;
      if (cycles > 20000) begin timeout = 1'b1; break; end
      if (pause_at >= 0 && !paused && n == pause_at) begin
        paused = 1'b1;
        hold_check(exp_q[pause_at]);
      end
      if (restart_at >= 0 && !restarted && n == restart_at) begin
        restarted = 1'b1; bus.start = 1'b1;
      end
      if (done_start && !dstart && n == NPIX) begin
        dstart = 1'b1; bus.start = 1'b1;
      end
      case (mode)
        0:       bus.data_request = 1'b1;
        1:       bus.data_request = (cycles % 16 == 0);
        default: bus.data_request = 1'($urandom_range(0, 1));
      endcase
    end
    bus.data_request = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.data_request = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.data_valid, bus.mem_rd_en, bus.busy, bus.frame_done, bus.data, bus.mem_addr} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: dv=%b rd=%b busy=%b fd=%b data=%0h addr=%0h, required all 0",
        bus.data_valid, bus.mem_rd_en, bus.busy, bus.frame_done, bus.data, bus.mem_addr);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.data_valid, bus.busy, bus.frame_done, bus.mem_rd_en} !== 4'b0) begin
      n_fail++; $display("FAIL idle_outputs: dv=%b busy=%b fd=%b rd=%b, required 0",
        bus.data_valid, bus.busy, bus.frame_done, bus.mem_rd_en);
    end
  endtask

  task automatic test_frame_identity();
    int base, fd0, rd0, v0, fb, errs, busy_hits;
    bit to;
    fill_mem(1'b0); build_expected();
    rd0 = rd_cnt; v0 = viol;
    run_frame(0, -1, -1, -1, 1'b1, base, fd0, to);
    busy_hits = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.busy) busy_hits++;
    end
    n_checks++;
    if (to) begin n_fail++; $display("FAIL ident_timeout: frame_done not seen, required within budget"); end
    n_checks++;
    if (got.size() - base !== NPIX) begin
      n_fail++; $display("FAIL ident_len: %0d pixels, required %0d", got.size() - base, NPIX);
    end
    errs = seq_errs(base, fb);
    n_checks++;
    if (errs !== 0) begin
      n_fail++; $display("FAIL ident_seq: %0d bad pixels, first k=%0d, required 0", errs, fb);
    end
    n_checks++;
    if (fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL ident_done: %0d pulses, required 1", fd_cnt - fd0); end
    n_checks++;
    if (rd_cnt - rd0 !== RD_EXP) begin
      n_fail++; $display("FAIL ident_reads: %0d reads, required %0d", rd_cnt - rd0, RD_EXP);
    end
    n_checks++;
    if (viol !== v0) begin n_fail++; $display("FAIL ident_protocol: %0d violations, required 0", viol - v0); end
    n_checks++;
    if (t_first - t_start !== 3) begin
      n_fail++; $display("FAIL ident_latency: %0d cycles, required 3", t_first - t_start);
    end
    n_checks++;
    if (min_gap(base) !== 3) begin n_fail++; $display("FAIL ident_gap: %0d cycles, required 3", min_gap(base)); end
    n_checks++;
    if (busy_hits !== 0) begin
      n_fail++; $display("FAIL done_start: busy for %0d cycles after start in DONE, required 0", busy_hits);
    end
`ifdef CONV_FEEDER_PAD_EN
    errs = 0;
    for (int k = 0; k < 66; k++) if (got[base + k] !== 8'h00) errs++;
    n_checks++;
    if (errs !== 0) begin n_fail++; $display("FAIL pad_top: %0d nonzero of pixels 0..65, required 0", errs); end
    n_checks++;
    if (got[base + 66] !== 8'd0 || got[base + 67] !== 8'd1) begin
      n_fail++; $display("FAIL pix_2_2_3: %0d,%0d, required 0,1", got[base + 66], got[base + 67]);
    end
    n_checks++;
    if (got[base + 98] !== 8'd28) begin n_fail++; $display("FAIL pix_3_2: %0d, required 28", got[base + 98]); end
    n_checks++;
    if (got[base + 29 * 32 + 29] !== 8'd15 || got[base + 1023] !== 8'd0) begin
      n_fail++; $display("FAIL pix_corner: %0d,%0d, required 15,0", got[base + 29 * 32 + 29], got[base + 1023]);
    end
`else
    errs = 0;
    for (int k = 0; k < NPIX; k++) begin
      int kk;
      kk = k % 256;
      if (got[base + k] !== kk[7:0]) errs++;
    end
    n_checks++;
    if (errs !== 0) begin n_fail++; $display("FAIL k_mod_256: %0d bad pixels, required 0", errs); end
`endif
  endtask

  task automatic test_request_pattern(input int mode);
    int base, fd0, v0, fb, errs;
    bit to;
    fill_mem(1'b1); build_expected();
    v0 = viol;
    run_frame(mode, -1, -1, -1, 1'b0, base, fd0, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL req%0d_timeout: frame_done not seen, required within budget", mode); end
    errs = seq_errs(base, fb);
    n_checks++;
    if (errs !== 0 || got.size() - base !== NPIX) begin
      n_fail++; $display("FAIL req%0d_seq: %0d bad, len %0d, first k=%0d, required 0 bad len %0d",
        mode, errs, got.size() - base, fb, NPIX);
    end
    n_checks++;
    if (viol !== v0 || fd_cnt - fd0 !== 1) begin
      n_fail++; $display("FAIL req%0d_protocol: viol %0d done %0d, required 0 and 1", mode, viol - v0, fd_cnt - fd0);
    end
    n_checks++;
    if (min_gap(base) < 3) begin n_fail++; $display("FAIL req%0d_gap: %0d, required >=3", mode, min_gap(base)); end
  endtask

  task automatic test_hold_low();
    int base, fd0, fb, errs;
    bit to;
    fill_mem(1'b1); build_expected();
    run_frame(0, -1, -1, 300, 1'b0, base, fd0, to);
    errs = seq_errs(base, fb);
    n_checks++;
    if (to || errs !== 0 || got.size() - base !== NPIX) begin
      n_fail++; $display("FAIL hold_seq: timeout %0d bad %0d len %0d first k=%0d, required 0 0 %0d",
        to, errs, got.size() - base, fb, NPIX);
    end
  endtask

  task automatic test_restart_ignored();
    int base, fd0, fb, errs;
    bit to;
    fill_mem(1'b1); build_expected();
    run_frame(0, 100, -1, -1, 1'b0, base, fd0, to);
    errs = seq_errs(base, fb);
    n_checks++;
    if (to || errs !== 0 || got.size() - base !== NPIX) begin
      n_fail++; $display("FAIL restart_seq: timeout %0d bad %0d len %0d first k=%0d, required 0 0 %0d",
        to, errs, got.size() - base, fb, NPIX);
    end
    n_checks++;
    if (fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL restart_done: %0d pulses, required 1", fd_cnt - fd0); end
  endtask

  task automatic test_reset_abort();
    int base, fd0, fb, errs, bad;
    bit to;
    fill_mem(1'b1); build_expected();
    run_frame(0, -1, 500, -1, 1'b0, base, fd0, to);
    rst_n = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if ({bus.data_valid, bus.mem_rd_en, bus.busy, bus.frame_done, bus.data, bus.mem_addr} !== '0) bad++;
    end
    n_checks++;
    if (to || bad !== 0) begin
      n_fail++; $display("FAIL abort_reset_outputs: timeout %0d, %0d nonzero cycles, required 0 0", to, bad);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (fd_cnt !== fd0 || got.size() - base !== 500) begin
      n_fail++; $display("FAIL abort_no_done: done %0d pixels %0d, required 0 and 500", fd_cnt - fd0, got.size() - base);
    end
    run_frame(0, -1, -1, -1, 1'b0, base, fd0, to);
    errs = seq_errs(base, fb);
    n_checks++;
    if (to || errs !== 0 || got.size() - base !== NPIX) begin
      n_fail++; $display("FAIL abort_restart_seq: timeout %0d bad %0d len %0d first k=%0d, required 0 0 %0d",
        to, errs, got.size() - base, fb, NPIX);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame_identity();
    test_request_pattern(1);
    test_request_pattern(2);
    test_hold_low();
    test_restart_ignored();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
